// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read and write controllers.
// FSM states, AXI encodings and the 4 KB page constant.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_t;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min of beats left, max burst and beats to 4 KB page end.
// Pure combinational; shared by the read and write controllers.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 26,
  parameter int BURST_LEN  = 16
) (
  input  logic [LEN_WIDTH-1:0] beats_left,
  input  logic [11:0]          addr_lo,
  output logic [8:0]           burst
);

  localparam int BPB_LOG = $clog2(DATA_WIDTH / 8);

  logic [12:0] to_bound;
  logic [12:0] cap;

  // clamp by page room, then by burst limit, then by what is left
  always_comb begin
    to_bound = (BOUNDARY_4K - {1'b0, addr_lo}) >> BPB_LOG;
    cap      = (to_bound < 13'(BURST_LEN)) ? to_bound : 13'(BURST_LEN);
    burst    = (beats_left < LEN_WIDTH'(cap)) ? beats_left[8:0] : cap[8:0];
  end

endmodule

// File: rtl/dma_write_control.sv
// AXI4 write-master DMA: AXI-Stream source into memory.
// INCR bursts split at 4 KB, one burst outstanding, IRQ on completion.
module dma_write_control
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 26,
  parameter int BURST_LEN  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    dma_write_valid,
  input  logic [ADDR_WIDTH-1:0]   dma_da_config,
  input  logic [LEN_WIDTH-1:0]    dma_length_config,
  output logic                    dma_idle,
  output logic                    DMA_IRQ,
  output logic                    dma_err,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready
);

  localparam int BPB_LOG = $clog2(DATA_WIDTH / 8);

  state_t                state;
  state_t                next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic [LEN_WIDTH-1:0]  beats_rem;
  logic [8:0]            burst;
  logic [8:0]            burst_calc;
  logic [8:0]            beat_cnt;
  logic                  last_beat;
  logic                  w_hs;

  dma_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) u_calc (
    .beats_left (beats_left),
    .addr_lo    (addr[11:0]),
    .burst      (burst_calc)
  );

  assign beats_rem = beats_left - LEN_WIDTH'(burst);
  assign last_beat = (beat_cnt == burst - 9'd1);
  assign w_hs      = s_tvalid && m_wready;

  assign m_awaddr  = addr;
  assign m_awlen   = 8'(burst - 9'd1);
  assign m_awsize  = 3'(BPB_LOG);
  assign m_awburst = BURST_INCR;
  assign m_wdata   = s_tdata;
  assign m_wstrb   = '1;

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next;
  end

  // next state and handshake outputs
  always_comb begin
    next      = state;
    dma_idle  = 1'b0;
    DMA_IRQ   = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    s_tready  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    unique case (state)
      IDLE: begin
        dma_idle = 1'b1;
        if (dma_write_valid) next = LOAD;
      end
      LOAD: next = (beats_left == '0) ? DONE : ADDR;
      ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) next = DATA;
      end
      DATA: begin
        m_wvalid = s_tvalid;
        s_tready = m_wready;
        m_wlast  = last_beat;
        if (w_hs && last_beat) next = RESP;
      end
      RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) next = (beats_rem != '0) ? LOAD : DONE;
      end
      DONE: begin
        DMA_IRQ = 1'b1;
        next    = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // address, length, burst and beat bookkeeping plus error flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr       <= '0;
      beats_left <= '0;
      burst      <= '0;
      beat_cnt   <= '0;
      dma_err    <= 1'b0;
    end else begin
      if (state == IDLE && dma_write_valid) begin
        addr       <= dma_da_config;
        beats_left <= dma_length_config >> BPB_LOG;
        dma_err    <= 1'b0;
      end
      if (state == LOAD) begin
        burst    <= burst_calc;
        beat_cnt <= '0;
      end
      if (state == DATA && w_hs) beat_cnt <= beat_cnt + 9'd1;
      if (state == RESP && m_bvalid) begin
        addr       <= addr + (ADDR_WIDTH'(burst) << BPB_LOG);
        beats_left <= beats_rem;
        if (m_bresp != RESP_OKAY) dma_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_write_control.sv
// Scoreboard bench for dma_write_control.
// Reference model plans bursts from page/burst rules; monitors check.
module tb_dma_write_control;

  logic        CLK = 0;
  logic        RST = 0;
  logic        dma_write_valid = 0;
  logic [31:0] dma_da_config = 0;
  logic [25:0] dma_length_config = 0;
  logic        dma_idle, DMA_IRQ, dma_err;
  logic [63:0] s_tdata = 0;
  logic        s_tvalid = 0;
  logic        s_tready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 0;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast, m_wvalid;
  logic        m_wready = 0;
  logic [1:0]  m_bresp = 0;
  logic        m_bvalid = 0;
  logic        m_bready;

  dma_write_control dut (
    .CLK(CLK), .RST(RST),
    .dma_write_valid(dma_write_valid),
    .dma_da_config(dma_da_config),
    .dma_length_config(dma_length_config),
    .dma_idle(dma_idle), .DMA_IRQ(DMA_IRQ), .dma_err(dma_err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] a; logic [7:0] l; } aw_t;
  typedef struct { logic [63:0] d; logic last; } w_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  bit          exp_irq[$];
  logic [63:0] src[$];

  int total = 0;
  int bad = 0;
  int irq_cnt = 0;
  int aw_hs = 0;
  int last_hs = 0;
  int w_hs = 0;
  bit bp = 0;
  bit err_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s act=unexpected exp=none t=%0t", nm, $time);
  endtask

  // reference: split into bursts by page room and max burst
  task automatic plan(input logic [31:0] addr, input logic [25:0] len);
    int unsigned beats, room, n;
    logic [31:0] a;
    logic [63:0] d;
    beats = len / 8;
    a = addr;
    while (beats > 0) begin
      room = (4096 - (a % 4096)) / 8;
      n = beats;
      if (n > 16) n = 16;
      if (n > room) n = room;
      exp_aw.push_back('{a, 8'(n - 1)});
      for (int i = 0; i < int'(n); i++) begin
        d = {$urandom, $urandom};
        src.push_back(d);
        exp_w.push_back('{d, i == int'(n) - 1});
      end
      a = a + n * 8;
      beats = beats - n;
    end
  endtask

  // stream source
  initial begin
    bit hs;
    forever begin
      @(negedge CLK);
      hs = s_tvalid && s_tready;
      @(posedge CLK);
      #1;
      if (hs && src.size() > 0) void'(src.pop_front());
      if (src.size() > 0 && (!bp || $urandom_range(0, 3) != 0)) begin
        s_tvalid = 1;
        s_tdata = src[0];
      end else begin
        s_tvalid = 0;
      end
    end
  end

  // AW and W ready generators
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      m_awready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      m_wready  = bp ? ($urandom_range(0, 1) == 0) : 1'b1;
    end
  end

  // write response slave
  initial begin
    forever begin
      @(negedge CLK);
      if (m_wvalid && m_wready && m_wlast) begin
        @(posedge CLK);
        #1;
        if (bp) repeat ($urandom_range(0, 4)) begin
          @(posedge CLK);
          #1;
        end
        m_bvalid = 1;
        m_bresp = err_mode ? 2'b10 : 2'b00;
        for (int k = 0; k < 50; k++) begin
          @(negedge CLK);
          if (m_bready) break;
        end
        @(posedge CLK);
        #1;
        m_bvalid = 0;
      end
    end
  end

  // AW monitor
  initial begin
    aw_t e;
    forever begin
      @(negedge CLK);
      if (RST && m_awvalid && m_awready) begin
        aw_hs++;
        if (exp_aw.size() == 0) miss("aw_extra");
        else begin
          e = exp_aw.pop_front();
          chk("awaddr", m_awaddr, e.a);
          chk("awlen", m_awlen, e.l);
        end
        chk("awsize", m_awsize, 3);
        chk("awburst", m_awburst, 1);
      end
    end
  end

  // W monitor
  initial begin
    w_t e;
    forever begin
      @(negedge CLK);
      if (RST && m_wvalid)
        chk("w_before_aw", (aw_hs - last_hs) == 1, 1);
      if (RST && m_wvalid && m_wready) begin
        w_hs++;
        if (exp_w.size() == 0) miss("w_extra");
        else begin
          e = exp_w.pop_front();
          chk("wdata", m_wdata, e.d);
          chk("wlast", m_wlast, e.last);
        end
        chk("wstrb", m_wstrb, 8'hFF);
        if (m_wlast) last_hs++;
      end
    end
  end

  // completion monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && DMA_IRQ) begin
        irq_cnt++;
        if (exp_irq.size() == 0) miss("irq_extra");
        else chk("irq_err", dma_err, exp_irq.pop_front());
        chk("irq_idle", dma_idle, 0);
      end
    end
  end

  task automatic run_xfer(input logic [31:0] a, input logic [25:0] len,
                          input bit b, input bit e, input bit poke);
    int  start_irq;
    bit  any;
    bp = b;
    err_mode = e;
    any = (len / 8) != 0;
    plan(a, len);
    exp_irq.push_back(e && any);
    start_irq = irq_cnt;
    @(posedge CLK);
    #1;
    dma_write_valid = 1;
    dma_da_config = a;
    dma_length_config = len;
    @(posedge CLK);
    #1;
    dma_write_valid = 0;
    chk("busy_after_start", dma_idle, 0);
    chk("err_cleared", dma_err, 0);
    chk("aw_lat1", m_awvalid, 0);
    @(posedge CLK);
    #1;
    if (!any) chk("zero_irq_lat", DMA_IRQ, 1);
    else chk("aw_lat2", m_awvalid, 1);
    for (int c = 0; c < 4000 && irq_cnt == start_irq; c++) begin
      if (poke && c == 4) begin
        dma_write_valid = 1;
        dma_da_config = 32'h800;
        dma_length_config = 26'h40;
      end else begin
        dma_write_valid = 0;
      end
      @(posedge CLK);
      #1;
    end
    dma_write_valid = 0;
    chk("irq_count", irq_cnt - start_irq, 1);
    @(posedge CLK);
    #1;
    chk("idle_after", dma_idle, 1);
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
    chk("src_left", src.size(), 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_idle", dma_idle, 1);
    chk("rst_irq", DMA_IRQ, 0);
    chk("rst_err", dma_err, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_awaddr", m_awaddr, 0);
  endtask

  initial begin
    int base;
    #3;
    chk_reset_outs();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1;

    run_xfer(32'h0, 26'h40, 0, 0, 0);
    run_xfer(32'h100, 26'h200, 0, 0, 0);
    run_xfer(32'hFC0, 26'h80, 0, 0, 0);
    run_xfer(32'h2FC0, 26'h100, 1, 0, 1);
    run_xfer(32'h500, 26'h0, 0, 0, 0);
    run_xfer(32'h40, 26'h40, 0, 1, 0);
    run_xfer(32'h80, 26'h40, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run_xfer(32'($urandom_range(0, 'h7FF)) * 8,
               26'($urandom_range(0, 'h180)),
               1'($urandom_range(0, 1)), 0, 0);

    bp = 0;
    err_mode = 0;
    plan(32'h0, 26'h40);
    base = w_hs;
    @(posedge CLK);
    #1;
    dma_write_valid = 1;
    dma_da_config = 32'h0;
    dma_length_config = 26'h40;
    @(posedge CLK);
    #1;
    dma_write_valid = 0;
    for (int c = 0; c < 200 && w_hs < base + 2; c++) begin
      @(posedge CLK);
      #1;
    end
    chk("beats_before_rst", w_hs - base, 2);
    chk("beat3_presented", m_wvalid, 1);
    #1;
    RST = 0;
    #1;
    chk_reset_outs();
    exp_aw.delete();
    exp_w.delete();
    exp_irq.delete();
    src.delete();
    last_hs = aw_hs;
    @(posedge CLK);
    #1;
    RST = 1;
    run_xfer(32'h0, 26'h40, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_write_control.md
Name: dma_write_control

Overview:
- AXI4 write-master DMA engine; the write-side counterpart of the DMA read controller.
- Moves a configured number of bytes from an AXI-Stream source (accelerator output buffer) into DDR, starting at a configured destination address.
- Splits the transfer into INCR bursts that never cross a 4 KB boundary.
- Reports completion with an IRQ pulse and an idle level, using the same start/idle/IRQ handshake as the read controller.

Parameters:
- DATA_WIDTH, 64, AXI/stream data width in bits; bytes per beat BPB = DATA_WIDTH/8.
- ADDR_WIDTH, 32, AXI address width.
- LEN_WIDTH, 26, width of the byte-length config.
- BURST_LEN, 16, maximum beats per burst (1..256).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- dma_write_valid  in  1  start strobe; sampled only while dma_idle=1
- dma_da_config  in  ADDR_WIDTH  destination byte address; must be BPB-aligned
- dma_length_config  in  LEN_WIDTH  transfer length in bytes; low log2(BPB) bits ignored
- dma_idle  out  1  engine idle, ready for a start
- DMA_IRQ  out  1  one-cycle completion pulse
- dma_err  out  1  sticky error flag; set by any BRESP!=OKAY, cleared on start
- s_tdata  in  DATA_WIDTH  stream data
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- m_awaddr  out  ADDR_WIDTH; m_awlen out 8; m_awsize out 3 (=log2 BPB); m_awburst out 2 (=INCR); m_awvalid out 1; m_awready in 1
- m_wdata  out  DATA_WIDTH; m_wstrb out BPB (all ones); m_wlast out 1; m_wvalid out 1; m_wready in 1
- m_bresp  in  2; m_bvalid in 1; m_bready out 1

Behaviour:
- Reset (RST=0, async): state IDLE; dma_idle=1; DMA_IRQ=0; dma_err=0; all valid/ready/last outputs 0; address and counter registers 0.
- IDLE → LOAD:
  - Fires when dma_write_valid=1 and dma_idle=1.
  - Latch addr=dma_da_config and beats_left=dma_length_config>>log2(BPB); clear dma_err; dma_idle falls on the next edge.
  - dma_write_valid while busy is ignored.
- LOAD (1 cycle):
  - If beats_left=0, go to DONE with no bus activity.
  - Otherwise compute burst = min(beats_left, BURST_LEN, (4096 - addr[11:0])/BPB); m_awlen=burst-1; go to ADDR.
- ADDR:
  - m_awvalid=1 with m_awaddr/m_awlen held stable until the m_awready handshake; then go to DATA.
  - No overlap: W never starts before AW is accepted.
- DATA:
  - Combinational pass-through: s_tready=m_wready, m_wvalid=s_tvalid, m_wdata=s_tdata.
  - Beat counter increments per W handshake; m_wlast=1 on beat burst-1.
  - After the last handshake, go to RESP.
  - s_tready=0 in every other state.
- RESP:
  - m_bready=1; on m_bvalid, if m_bresp!=0 set dma_err.
  - Update addr+=burst*BPB and beats_left-=burst.
  - Go to LOAD if beats_left>0, else DONE.
  - An error does not abort the transfer.
- DONE (1 cycle): DMA_IRQ=1; go to IDLE, where dma_idle=1.
- Latency: start → first m_awvalid = 2 cycles (IDLE→LOAD→ADDR).
- Only one outstanding burst at any time.
- All arithmetic is unsigned.
- addr wrap past 2^ADDR_WIDTH is not checked; the 4 KB split guarantees a legal AXI burst.
- Reset mid-transfer: abort immediately and drop all valids. The slave-side AXI state is the system's responsibility, since reset is global.

Decomposition:
- Shared package dma_pkg:
  - state enum {IDLE, LOAD, ADDR, DATA, RESP, DONE}
  - AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00
  - 4 KB boundary constant
  - the read and write controllers share it.
- One sub-module, dma_burst_calc: combinational min(beats_left, BURST_LEN, beats to 4 KB boundary) → burst beats. It is reused by the read controller.

Test Plan:
- Basic: addr 0x0000, length 0x40, slave always ready → one AW (awaddr=0, awlen=7), 8 W beats with wlast on beat 8, BRESP OKAY, DMA_IRQ pulse, dma_idle=1, dma_err=0.
- Multi-burst: addr 0x100, length 0x200 → 4 bursts with awlen=15 at 0x100, 0x180, 0x200, 0x280; stream data arrives in DDR in order.
- 4 KB split: addr 0xFC0, length 0x80 → two bursts, 0xFC0 awlen=7 then 0x1000 awlen=7.
- Backpressure: random s_tvalid and m_wready/m_awready/m_bvalid delays, length 0x100 → no lost or duplicated beats; wlast only on beat 16; no m_wvalid before the AW handshake.
- Zero length and error: length 0x0 → DMA_IRQ 2 cycles after start with no AW. Then length 0x40 with bresp=SLVERR → dma_err=1 and DMA_IRQ still fires; the next start clears dma_err.
- Reset mid-burst: RST low during beat 3 → all outputs return to reset values asynchronously; after release, a new start at 0x0, length 0x40 completes normally.
